// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, encoder FSM states and instruction format
// classes used by both the instruction encoder and the decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_J,
        FMT_ILLEGAL
    } fmt_e;

    function automatic fmt_e op_format(input logic [5:0] op);
        fmt_e f;
        case (op)
            OP_RTYPE:                           f = FMT_R;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_LUI:                             f = FMT_I;
            OP_J, OP_JAL:                       f = FMT_J;
            default:                            f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty/count; push and pop may occur together.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage holds data only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs decoded MIPS field tuples into 32-bit words and streams them into
// instruction memory through a buffered, stallable write port.
module inst_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        func,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        sa,
    input  logic [15:0]       immediate,
    input  logic [25:0]       address,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W:0]   words_written
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = ADDR_W + 2;
    localparam logic [SW-1:0]     MEM_LIM  = SW'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              err_q, err_d;

    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       fifo_head;
    logic [31:0]       enc_word;
    fmt_e              fmt;
    logic              accept, push, pop;
    logic [SW-1:0]     occupancy;

    // Words already committed plus words still buffered bound further accepts.
    assign occupancy = SW'(wcnt_q) + SW'(fifo_count);

    always_comb begin
        fmt = op_format(opcode);
        case (fmt)
            FMT_R:   enc_word = {opcode, rs, rt, rd, sa, func};
            FMT_I:   enc_word = {opcode, rs, rt, immediate};
            FMT_J:   enc_word = {opcode, address};
            default: enc_word = 32'h0;
        endcase
    end

    assign in_ready = (state_q == ST_LOAD) && !fifo_full && (occupancy < MEM_LIM);
    assign accept   = in_valid && in_ready;
    assign push     = accept && (fmt != FMT_ILLEGAL);
    assign mem_we   = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && !fifo_empty;
    assign pop      = mem_we && mem_ready;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (enc_word),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        if (pop) begin
            wcnt_d = wcnt_q + (ADDR_W+1)'(1);
            // Saturate rather than wrap when memory spans the full address space.
            if (addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
        end
        if (accept && (fmt == FMT_ILLEGAL)) err_d = 1'b1;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = '0;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD:  if (finish || (occupancy >= MEM_LIM)) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_wdata     = mem_we ? fifo_head : 32'h0;
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign err_illegal   = err_q;
    assign words_written = wcnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: a default-size instance plus a 4-word
// instance for the capacity limit and address saturation.
module tb_inst_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, finish, in_valid, mem_ready;
    logic        start_s, finish_s, in_valid_s;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] immediate;
    logic [25:0] address;

    logic        in_ready, mem_we, busy, done, err_illegal;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  words_written;

    logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_ww;

    inst_encoder #(.ADDR_W(8), .MEM_WORDS(256), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
        .immediate(immediate), .address(address),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .err_illegal(err_illegal), .words_written(words_written)
    );

    inst_encoder #(.ADDR_W(2), .MEM_WORDS(4), .FIFO_DEPTH(4)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .finish(finish_s),
        .in_valid(in_valid_s), .in_ready(s_in_ready),
        .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .sa(sa),
        .immediate(immediate), .address(address),
        .mem_we(s_mem_we), .mem_ready(mem_ready), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .busy(s_busy), .done(s_done),
        .err_illegal(s_err), .words_written(s_ww)
    );

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];
    logic [39:0] sexp_q[$];
    logic [31:0] wlog[$];
    int exp_idx = 0, sexp_idx = 0, n_acc = 0, s_acc = 0;
    int sess_id = 0, last_sess = 0;
    bit rand_mr = 1'b0;
    logic        hold_v = 1'b0;
    logic [7:0]  hold_addr;
    logic [31:0] hold_data;
    logic [5:0]  legal_ops [12] = '{6'd0, 6'd8, 6'd12, 6'd13, 6'd14, 6'd35,
                                    6'd43, 6'd4, 6'd5, 6'd15, 6'd2, 6'd3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference packing from the MIPS field positions.
    function automatic bit ref_enc(input logic [5:0] op, input logic [4:0] f_rs,
                                   input logic [4:0] f_rt, input logic [4:0] f_rd,
                                   input logic [4:0] f_sa, input logic [5:0] f_fn,
                                   input logic [15:0] f_imm, input logic [25:0] f_adr,
                                   output logic [31:0] w);
        logic [31:0] hi;
        hi = 32'(op) << 26;
        w  = 32'h0;
        if (op == 6'd0) begin
            w = hi | (32'(f_rs) << 21) | (32'(f_rt) << 16) | (32'(f_rd) << 11)
                   | (32'(f_sa) << 6) | 32'(f_fn);
            return 1'b1;
        end
        if (op inside {6'd8, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43, 6'd4, 6'd5, 6'd15}) begin
            w = hi | (32'(f_rs) << 21) | (32'(f_rt) << 16) | 32'(f_imm);
            return 1'b1;
        end
        if (op inside {6'd2, 6'd3}) begin
            w = hi | 32'(f_adr);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin : recorder
        logic [31:0] w;
        if (rst) begin
            exp_q.delete();
            sexp_q.delete();
            exp_idx  = 0;
            sexp_idx = 0;
        end else begin
            if (sess_id != last_sess) begin
                last_sess = sess_id;
                exp_idx   = 0;
            end
            if (in_valid && in_ready) begin
                n_acc++;
                if (ref_enc(opcode, rs, rt, rd, sa, func, immediate, address, w)) begin
                    exp_q.push_back({8'(exp_idx), w});
                    exp_idx++;
                end
            end
            if (in_valid_s && s_in_ready) begin
                s_acc++;
                if (ref_enc(opcode, rs, rt, rd, sa, func, immediate, address, w)) begin
                    sexp_q.push_back({8'(sexp_idx), w});
                    sexp_idx++;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [39:0] e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_we", mem_we, 1);
                chk("stall_addr", mem_addr, hold_addr);
                chk("stall_wdata", mem_wdata, hold_data);
            end
            hold_v    = mem_we && !mem_ready;
            hold_addr = mem_addr;
            hold_data = mem_wdata;
            if (mem_we && mem_ready) begin
                wlog.push_back(mem_wdata);
                chk("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("mem_wdata", mem_wdata, e[31:0]);
                    chk("mem_addr", mem_addr, e[39:32]);
                end
            end
            if (s_mem_we && mem_ready) begin
                chk("s_write_expected", sexp_q.size() != 0, 1);
                if (sexp_q.size() != 0) begin
                    e = sexp_q.pop_front();
                    chk("s_mem_wdata", s_mem_wdata, e[31:0]);
                    chk("s_mem_addr", s_mem_addr, e[39:32]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mr) mem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic rand_fields();
        opcode    = 6'($urandom);
        func      = 6'($urandom);
        rs        = 5'($urandom);
        rt        = 5'($urandom);
        rd        = 5'($urandom);
        sa        = 5'($urandom);
        immediate = 16'($urandom);
        address   = 26'($urandom);
    endtask

    task automatic rand_legal();
        rand_fields();
        opcode = legal_ops[$urandom_range(0, 11)];
    endtask

    task automatic offer();
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) chk("offer_timeout", 0, 1);
    endtask

    task automatic new_session();
        sess_id++;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        chk("done_reached", done, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_illegal, 0);
        chk({tag, "_ww"}, words_written, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int base, a0, legal_cnt;
        bit ill;
        logic [31:0] w;
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        start_s = 1'b0; finish_s = 1'b0; in_valid_s = 1'b0;
        rand_fields();
        repeat (3) tick();
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Single add: visible on the port one cycle after acceptance.
        new_session();
        rand_fields();
        opcode = 6'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; sa = 5'd0; func = 6'h20;
        offer();
        @(negedge clk);
        chk("add_we", mem_we, 1);
        chk("add_addr", mem_addr, 0);
        chk("add_wdata", mem_wdata, 32'h00221820);
        tick();
        chk("add_ww", words_written, 1);
        pulse_finish();
        wait_done(50);

        // addi, lw, j back to back.
        new_session();
        base = wlog.size();
        rand_fields(); opcode = 6'd8;  rs = 5'd0;  rt = 5'd8; immediate = 16'd5; offer();
        rand_fields(); opcode = 6'd35; rs = 5'd29; rt = 5'd9; immediate = 16'd4; offer();
        rand_fields(); opcode = 6'd2;  address = 26'h0100000; offer();
        pulse_finish();
        wait_done(50);
        chk("b2b_count", wlog.size() - base, 3);
        if (wlog.size() >= base + 3) begin
            chk("b2b_addi", wlog[base], 32'h20080005);
            chk("b2b_lw", wlog[base+1], 32'h8FA90004);
            chk("b2b_j", wlog[base+2], 32'h08100000);
        end
        chk("b2b_ww", words_written, 3);

        // Stalled memory: the buffer fills after four accepts.
        new_session();
        base = wlog.size();
        mem_ready = 1'b0;
        a0 = n_acc;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    rand_legal();
                    offer();
                end
            end
            begin
                repeat (10) tick();
                chk("stall_accepts", n_acc - a0, 4);
                chk("stall_in_ready", in_ready, 0);
                mem_ready = 1'b1;
            end
        join
        pulse_finish();
        wait_done(50);
        chk("stall_written", wlog.size() - base, 6);
        chk("stall_ww", words_written, 6);
        chk("stall_queue_empty", exp_q.size(), 0);

        // Illegal opcode between two legal tuples.
        new_session();
        chk("illegal_err_clear", err_illegal, 0);
        rand_legal(); offer();
        rand_fields(); opcode = 6'h3F; offer();
        rand_legal(); offer();
        pulse_finish();
        wait_done(50);
        chk("illegal_err", err_illegal, 1);
        chk("illegal_ww", words_written, 2);

        // Reset during DRAIN discards buffered words.
        new_session();
        chk("restart_err_cleared", err_illegal, 0);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_legal();
            offer();
        end
        pulse_finish();
        tick();
        chk("drain_busy", busy, 1);
        chk("drain_we", mem_we, 1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();
        new_session();
        rand_legal(); offer();
        pulse_finish();
        wait_done(50);
        chk("after_rst_ww", words_written, 1);
        chk("after_rst_queue", exp_q.size(), 0);

        // 4-word memory: capacity stops the session on its own.
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int k = 0; k < 30; k++) begin
            rand_legal();
            in_valid_s = 1'b1;
            tick();
        end
        in_valid_s = 1'b0;
        tick();
        chk("cap_accepts", s_acc, 4);
        chk("cap_done", s_done, 1);
        chk("cap_busy", s_busy, 0);
        chk("cap_ww", s_ww, 4);
        chk("cap_in_ready", s_in_ready, 0);
        chk("cap_addr_sat", s_mem_addr, 3);
        chk("cap_queue", sexp_q.size(), 0);

        // Randomised sessions with a jittering memory ready.
        rand_mr = 1'b1;
        for (int s = 0; s < 3; s++) begin
            new_session();
            legal_cnt = 0;
            ill = 1'b0;
            for (int k = 0; k < 30; k++) begin
                rand_fields();
                if ($urandom_range(0, 7) == 0) opcode = 6'($urandom_range(16, 31));
                else opcode = legal_ops[$urandom_range(0, 11)];
                if (ref_enc(opcode, rs, rt, rd, sa, func, immediate, address, w)) legal_cnt++;
                else ill = 1'b1;
                offer();
                if ($urandom_range(0, 3) == 0) tick();
                if (k == 15) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end
            end
            pulse_finish();
            wait_done(400);
            chk("rand_ww", words_written, legal_cnt);
            chk("rand_err", err_illegal, ill);
            chk("rand_queue", exp_q.size(), 0);
        end
        rand_mr = 1'b0;
        mem_ready = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the instruction decoder. Accepts decoded MIPS field tuples over a valid/ready handshake and packs each into a 32-bit R/I/J-format word.
- Buffers the packed words and writes them sequentially into instruction memory through a stallable write port.
- Used as the program loader and as the stimulus generator for the decoder and CPU benches.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MEM_WORDS, 256, capacity in words; must be ≤ 2**ADDR_W.
- FIFO_DEPTH, 4, encoded-word buffer depth; must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a load session at word address 0
- finish  in  1  pulse: end of program; drain the buffer, then signal done
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder can accept a tuple
- opcode  in  6  MIPS opcode
- func  in  6  R-type function field
- rs, rt, rd, sa  in  5 each  register and shamt fields
- immediate  in  16  I-type immediate
- address  in  26  J-type target
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts the write this cycle
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  session in LOAD or DRAIN
- done  out  1  session complete; level, held until next start or rst
- err_illegal  out  1  sticky: an unsupported opcode was accepted this session
- words_written  out  ADDR_W+1  count of words committed to memory

Behaviour:
- Reset: FSM IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err_illegal=0, words_written=0; FIFO emptied. rst mid-session aborts immediately, and words in the FIFO are discarded.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE→LOAD on start.
  - LOAD→DRAIN on finish, or when words_written + fifo_count reaches MEM_WORDS.
  - DRAIN→DONE when the FIFO is empty.
  - DONE→LOAD on start.
  - start in LOAD or DRAIN is ignored. finish outside LOAD is ignored.
  - start and finish in the same cycle in IDLE or DONE: start wins, finish is dropped.
  - Entering LOAD clears mem_addr, words_written, err_illegal and done.
- in_ready = (state==LOAD) && FIFO not full && (words_written + fifo_count < MEM_WORDS). A tuple is accepted when in_valid && in_ready.
- Encoding is combinational on the accepted tuple and the result is written to the FIFO at that edge.
  - opcode 000000: {opcode, rs, rt, rd, sa, func}.
  - opcodes 001000, 001100, 001101, 001110, 100011, 101011, 000100, 000101, 001111: {opcode, rs, rt, immediate}.
  - opcodes 000010, 000011: {opcode, address}.
  - Any other opcode: the tuple is accepted, nothing is written to the FIFO, and err_illegal is set at the next edge.
  - Fields that do not belong to the instruction's format are ignored.
- Latency: a tuple accepted at edge N gives mem_we=1 with that word during cycle N+1 if the FIFO was empty. The word order on the memory port is the acceptance order.
- Write port:
  - mem_we = FIFO not empty, asserted in LOAD or DRAIN only. mem_wdata = FIFO head. mem_addr = current pointer.
  - On mem_we && mem_ready the FIFO pops, mem_addr increments and words_written increments.
  - With mem_ready=0, mem_we, mem_addr and mem_wdata hold stable.
- Simultaneous FIFO push and pop in one cycle are both performed and fifo_count is unchanged. The full check uses the pre-edge count, so no bubble is needed when the FIFO is not full.
- Capacity: words_written never exceeds MEM_WORDS and mem_addr never wraps. When MEM_WORDS == 2**ADDR_W, mem_addr stays at MEM_WORDS-1 after the last write.
- busy = state ∈ {LOAD, DRAIN}. done=1 only in DONE.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_LUI, OP_J, OP_JAL);
  - the FSM state encoding;
  - format-class constants shared with the decoder.
- Sub-module sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH): full, empty and count outputs, push and pop allowed in the same cycle, synchronous reset.

Test Plan:
- start; one tuple add (op 0, rs=1, rt=2, rd=3, sa=0, func=100000) with mem_ready=1 → one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00221820; words_written=1.
- Back-to-back addi (rs=0, rt=8, imm=5), lw (rs=29, rt=9, imm=4), j (address=0x0100000) → words 0x20080005, 0x8FA90004, 0x08100000 at addresses 0, 1, 2 on consecutive cycles.
- mem_ready=0 for 10 cycles while 6 tuples are offered → in_ready drops after 4 accepts; mem_we, mem_addr and mem_wdata are stable throughout. Release mem_ready → all 6 words written in order with no loss or duplication.
- Tuple with opcode 111111 between two valid tuples → err_illegal=1; only 2 words written, at consecutive addresses 0 and 1.
- MEM_WORDS=4 with 6 tuples offered → exactly 4 accepted; FSM goes to DRAIN, then done=1, words_written=4; in_ready stays 0.
- finish after 3 words, then rst asserted during DRAIN with mem_ready=0 → all outputs at reset values the next cycle. A new start then writes from address 0.
